// File: rtl/bsg_cgol_ctrl_if.sv
// Handshake and cell-array bus between the Game-of-Life controller and its neighbours.
// slave = controller side, master = upstream/downstream/cell-array side.
interface bsg_cgol_ctrl_if #(
    parameter int board_width_p     = 32,
    parameter int max_game_length_p = 10000
);
    localparam int B  = board_width_p * board_width_p;
    localparam int CW = $clog2(max_game_length_p + 1);

    logic          valid_i;
    logic [B-1:0]  data_i;
    logic [CW-1:0] frames_i;
    logic          ready_o;

    logic          en_o;
    logic          update_o;
    logic [B-1:0]  update_val_o;
    logic [B-1:0]  cell_data_i;

    logic          valid_o;
    logic [B-1:0]  data_o;
    logic          yumi_i;

    modport slave (
        input  valid_i, data_i, frames_i, cell_data_i, yumi_i,
        output ready_o, en_o, update_o, update_val_o, valid_o, data_o
    );

    modport master (
        output valid_i, data_i, frames_i, cell_data_i, yumi_i,
        input  ready_o, en_o, update_o, update_val_o, valid_o, data_o
    );
endinterface

// File: rtl/bsg_cgol_ctrl.sv
// Game-of-Life controller: accepts a board and a frame count, loads the cell array,
// pulses en_o once per generation, then presents the final board until consumed.
module bsg_cgol_ctrl #(
    parameter int board_width_p     = 32,
    parameter int max_game_length_p = 10000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    bsg_cgol_ctrl_if.slave   io
);
    localparam int B  = board_width_p * board_width_p;
    localparam int CW = $clog2(max_game_length_p + 1);
    localparam logic [CW-1:0] MAX_FRAMES = CW'(max_game_length_p);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_e;

    state_e        state_r, state_n;
    logic [B-1:0]  board_r;
    logic [CW-1:0] frames_r;
    logic          drain_r;

    logic ready_c, en_c, update_c, valid_c;
    logic accept;

    // Requests longer than the supported game are clamped rather than rejected.
    function automatic logic [CW-1:0] sat_frames(input logic [CW-1:0] f);
        return (f > MAX_FRAMES) ? MAX_FRAMES : f;
    endfunction

    // drain_r holds ready_o low for the cycle in which valid_o falls.
    assign ready_c = (state_r == S_IDLE) && !drain_r;
    assign accept  = ready_c && io.valid_i && !reset_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= S_IDLE;
            frames_r <= '0;
            board_r  <= '0;
            drain_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            drain_r <= (state_r == S_DONE) && io.yumi_i;
            if (accept) begin
                board_r  <= io.data_i;
                frames_r <= sat_frames(io.frames_i);
            end else if (state_r == S_RUN) begin
                frames_r <= frames_r - CW'(1);
            end
        end
    end

    always_comb begin
        state_n  = state_r;
        en_c     = 1'b0;
        update_c = 1'b0;
        valid_c  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (accept) state_n = S_LOAD;
            end
            S_LOAD: begin
                update_c = 1'b1;
                state_n  = (frames_r != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                en_c = 1'b1;
                if (frames_r == CW'(1)) state_n = S_DONE;
            end
            S_DONE: begin
                valid_c = 1'b1;
                if (io.yumi_i) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Reset masks every strobe immediately so the cell array freezes in the reset cycle.
    assign io.ready_o      = ready_c  && !reset_i;
    assign io.en_o         = en_c     && !reset_i;
    assign io.update_o     = update_c && !reset_i;
    assign io.valid_o      = valid_c  && !reset_i;
    assign io.update_val_o = board_r;
    assign io.data_o       = io.cell_data_i;
endmodule

// File: tb/tb_bsg_cgol_ctrl.sv
// Bench for bsg_cgol_ctrl on a 4x4 board with a behavioural dead-boundary cell array.
module tb_bsg_cgol_ctrl;
    localparam int W   = 4;
    localparam int MAX = 20;
    localparam int B   = W * W;
    localparam int CW  = $clog2(MAX + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bsg_cgol_ctrl_if #(.board_width_p(W), .max_game_length_p(MAX)) ifc ();

    bsg_cgol_ctrl #(.board_width_p(W), .max_game_length_p(MAX)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .io      (ifc)
    );

    // Conway rules on a finite grid; cells beyond the edge count as dead.
    function automatic logic [B-1:0] life_step(input logic [B-1:0] b);
        logic [B-1:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < W && c + dc >= 0 && c + dc < W)
                            cnt += int'(b[(r + dr) * W + (c + dc)]);
                n[r * W + c] = (cnt == 3) || (b[r * W + c] && cnt == 2);
            end
        end
        return n;
    endfunction

    function automatic logic [B-1:0] ref_life(input logic [B-1:0] b, input int gens);
        logic [B-1:0] x;
        x = b;
        for (int g = 0; g < gens; g++) x = life_step(x);
        return x;
    endfunction

    logic [B-1:0] cells = '0;
    always @(posedge clk) begin
        if (ifc.update_o)   cells <= ifc.update_val_o;
        else if (ifc.en_o)  cells <= life_step(cells);
    end
    assign ifc.cell_data_i = cells;

    task automatic drive_junk(input bit junk);
        ifc.valid_i  = junk ? 1'($urandom) : 1'b0;
        ifc.data_i   = B'($urandom);
        ifc.frames_i = CW'($urandom);
    endtask

    // Handshake one game and follow it to DONE, checking every cycle's strobes.
    task automatic run_game(input logic [B-1:0] d, input logic [CW-1:0] f, input bit junk);
        int budget, k, n_eff, first_valid;
        logic exp_en;
        logic [B-1:0] exp_board;
        n_eff = (int'(f) > MAX) ? MAX : int'(f);
        exp_board = ref_life(d, n_eff);
        budget = 0;
        while (ifc.ready_o !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (ifc.ready_o !== 1'b1) begin
            failures++;
            $display("FAIL ready_wait: ready_o=%b required 1", ifc.ready_o);
        end
        ifc.valid_i  = 1'b1;
        ifc.data_i   = d;
        ifc.frames_i = f;
        @(negedge clk);
        drive_junk(junk);
        checks++;
        if (ifc.update_o !== 1'b1 || ifc.en_o !== 1'b0 || ifc.ready_o !== 1'b0 || ifc.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL load_strobes: update=%b en=%b ready=%b valid=%b required 1 0 0 0",
                     ifc.update_o, ifc.en_o, ifc.ready_o, ifc.valid_o);
        end
        checks++;
        if (ifc.update_val_o !== d) begin
            failures++;
            $display("FAIL load_value: update_val_o=%h required %h", ifc.update_val_o, d);
        end
        k = 1;
        first_valid = -1;
        while (k < 100) begin
            @(negedge clk);
            k++;
            drive_junk(junk);
            if (ifc.valid_o === 1'b1) begin
                first_valid = k;
                break;
            end
            exp_en = (k >= 2) && (k <= 1 + n_eff);
            checks++;
            if (ifc.en_o !== exp_en || ifc.update_o !== 1'b0 || ifc.ready_o !== 1'b0) begin
                failures++;
                $display("FAIL run_cycle%0d: en=%b update=%b ready=%b required en=%b update=0 ready=0",
                         k, ifc.en_o, ifc.update_o, ifc.ready_o, exp_en);
            end
        end
        ifc.valid_i = 1'b0;
        checks++;
        if (first_valid != 2 + n_eff) begin
            failures++;
            $display("FAIL valid_latency: first valid at %0d required %0d (frames=%0d)", first_valid, 2 + n_eff, f);
        end
        checks++;
        if (ifc.data_o !== exp_board || ifc.en_o !== 1'b0 || ifc.ready_o !== 1'b0) begin
            failures++;
            $display("FAIL final_board: data_o=%h en=%b ready=%b required %h 0 0",
                     ifc.data_o, ifc.en_o, ifc.ready_o, exp_board);
        end
    endtask

    // Consume in DONE while offering a new game that must not be taken in the falling cycle.
    task automatic consume();
        ifc.yumi_i  = 1'b1;
        ifc.valid_i = 1'b1;
        ifc.data_i  = B'($urandom);
        @(negedge clk);
        ifc.yumi_i = 1'b0;
        checks++;
        if (ifc.valid_o !== 1'b0 || ifc.ready_o !== 1'b0 || ifc.update_o !== 1'b0) begin
            failures++;
            $display("FAIL consume_fall: valid=%b ready=%b update=%b required 0 0 0",
                     ifc.valid_o, ifc.ready_o, ifc.update_o);
        end
        @(negedge clk);
        ifc.valid_i = 1'b0;
        checks++;
        if (ifc.ready_o !== 1'b1 || ifc.update_o !== 1'b0 || ifc.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL consume_idle: ready=%b update=%b valid=%b required 1 0 0",
                     ifc.ready_o, ifc.update_o, ifc.valid_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ifc.ready_o !== 1'b0 || ifc.en_o !== 1'b0 || ifc.update_o !== 1'b0 || ifc.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b en=%b update=%b valid=%b required 0 0 0 0",
                     ifc.ready_o, ifc.en_o, ifc.update_o, ifc.valid_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (ifc.ready_o !== 1'b1 || ifc.en_o !== 1'b0 || ifc.update_o !== 1'b0 || ifc.valid_o !== 1'b0) begin
                failures++;
                $display("FAIL idle_cycle%0d: ready=%b en=%b update=%b valid=%b required 1 0 0 0",
                         i, ifc.ready_o, ifc.en_o, ifc.update_o, ifc.valid_o);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_blinker();
        run_game(16'h0070, CW'(1), 1'b0);
        checks++;
        if (ifc.data_o !== 16'h0222) begin
            failures++;
            $display("FAIL blinker1: data_o=%h required 0222", ifc.data_o);
        end
        consume();
        run_game(16'h0070, CW'(2), 1'b1);
        checks++;
        if (ifc.data_o !== 16'h0070) begin
            failures++;
            $display("FAIL blinker2: data_o=%h required 0070", ifc.data_o);
        end
        consume();
    endtask

    task automatic test_zero_frames();
        run_game(16'hA5A5, CW'(0), 1'b1);
        checks++;
        if (ifc.data_o !== 16'hA5A5) begin
            failures++;
            $display("FAIL zero_frames: data_o=%h required a5a5", ifc.data_o);
        end
        consume();
    endtask

    task automatic test_hold();
        run_game(16'h0070, CW'(1), 1'b0);
        for (int i = 0; i < 20; i++) begin
            ifc.valid_i = 1'($urandom);
            ifc.data_i  = B'($urandom);
            @(negedge clk);
            checks++;
            if (ifc.valid_o !== 1'b1 || ifc.data_o !== 16'h0222 || ifc.ready_o !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d: valid=%b data_o=%h ready=%b required 1 0222 0",
                         i, ifc.valid_o, ifc.data_o, ifc.ready_o);
            end
        end
        consume();
    endtask

    task automatic test_reset_midrun();
        logic [B-1:0] d;
        d = B'($urandom);
        ifc.valid_i  = 1'b1;
        ifc.data_i   = d;
        ifc.frames_i = CW'(5);
        @(negedge clk);
        ifc.valid_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ifc.en_o !== 1'b1) begin
            failures++;
            $display("FAIL midrun_en: en=%b required 1", ifc.en_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ifc.en_o !== 1'b0 || ifc.ready_o !== 1'b0 || ifc.update_o !== 1'b0 || ifc.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset: en=%b ready=%b update=%b valid=%b required 0 0 0 0",
                     ifc.en_o, ifc.ready_o, ifc.update_o, ifc.valid_o);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ifc.ready_o !== 1'b1 || ifc.en_o !== 1'b0) begin
            failures++;
            $display("FAIL after_reset: ready=%b en=%b required 1 0", ifc.ready_o, ifc.en_o);
        end
        run_game(B'($urandom), CW'(3), 1'b1);
        consume();
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_game(B'($urandom), CW'($urandom_range(0, 7)), 1'b1);
            consume();
        end
    endtask

    task automatic test_saturation();
        run_game(B'($urandom), CW'(MAX), 1'b1);
        consume();
        run_game(B'($urandom), CW'($urandom_range(MAX + 1, (1 << CW) - 1)), 1'b1);
        consume();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            run_game(B'($urandom), CW'(i), 1'b0);
            consume();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.valid_i  = 1'b0;
        ifc.data_i   = '0;
        ifc.frames_i = '0;
        ifc.yumi_i   = 1'b0;
        @(negedge clk);
        test_reset();
        test_blinker();
        test_zero_frames();
        test_hold();
        test_reset_midrun();
        test_random();
        test_saturation();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bsg_cgol_ctrl.md
BSG_CGOL_CTRL -- requirements
Module: bsg_cgol_ctrl

Interface
REQ-001 Parameter board_width_p, default 32: board is board_width_p x board_width_p cells; let B = board_width_p*board_width_p.
REQ-002 Parameter max_game_length_p, default 10000: largest frame count accepted; let CW = $clog2(max_game_length_p+1).
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk_i  in  1  clock; all state updates on its rising edge.
REQ-005 reset_i  in  1  synchronous active-high reset.
REQ-006 valid_i  in  1  upstream offers an initial board and frame count.
REQ-007 data_i  in  B  initial board; bit r*board_width_p+c is the cell at row r, column c; 1 = alive.
REQ-008 frames_i  in  CW  number of generations to simulate.
REQ-009 ready_o  out  1  controller can accept a new game.
REQ-010 en_o  out  1  to every cell's en_i: simulate one generation.
REQ-011 update_o  out  1  to every cell's update_i: load update_val_o.
REQ-012 update_val_o  out  B  per-cell load value; bit mapping as data_i.
REQ-013 cell_data_i  in  B  per-cell data_o from the cell array; bit mapping as data_i.
REQ-014 valid_o  out  1  final board available.
REQ-015 data_o  out  B  final board.
REQ-016 yumi_i  in  1  downstream consumes data_o; legal only while valid_o=1.

Function
REQ-017 FSM states: IDLE, LOAD, RUN, DONE; encoding is free.
REQ-018 IDLE: ready_o=1, en_o=0, update_o=0, valid_o=0.
REQ-019 IDLE with valid_i=1: the handshake fires; data_i goes to a B-bit board register; frames_i goes to a CW-bit frame counter; next state is LOAD.
REQ-020 LOAD lasts exactly one cycle: update_o=1, en_o=0, update_val_o = board register, ready_o=0.
REQ-021 LOAD exit: next state is RUN if the frame counter is nonzero; otherwise next state is DONE.
REQ-022 RUN: en_o=1, update_o=0, ready_o=0; the frame counter decrements by 1 each cycle.
REQ-023 RUN exit: when the counter equals 1, next state is DONE; en_o is therefore high for exactly frames_i consecutive cycles.
REQ-024 en_o and update_o are never both 1 in the same cycle.
REQ-025 DONE: valid_o=1, data_o = cell_data_i, en_o=0, update_o=0, ready_o=0.
REQ-026 DONE holds; data_o is stable for as long as valid_o is high.
REQ-027 DONE with yumi_i=1: next state is IDLE; valid_o falls on the next cycle.
REQ-028 Latency: handshake in cycle T, then update_o in cycle T+1, then en_o in cycles T+2 through T+1+N, then valid_o first asserted in cycle T+2+N (N = frames_i).
REQ-029 frames_i=0: valid_o is first asserted in cycle T+2; data_o equals the loaded board.
REQ-030 frames_i > max_game_length_p: the count saturates to max_game_length_p at the handshake.
REQ-031 valid_i is ignored outside IDLE; a new game is never accepted in the cycle valid_o falls (ready_o rises one cycle later).
REQ-032 update_val_o equals the board register in every state; it is meaningful only while update_o=1.
REQ-033 data_o equals cell_data_i in every state; it is meaningful only while valid_o=1.
REQ-034 yumi_i outside DONE is ignored.

Reset
REQ-035 reset_i=1: next state is IDLE, frame counter = 0, board register = 0.
REQ-036 During the reset cycle: ready_o=0, en_o=0, update_o=0, valid_o=0.
REQ-037 First cycle after reset deasserts: ready_o=1.
REQ-038 Reset has priority over all other inputs.
REQ-039 Reset in any state (including mid-RUN or DONE) aborts the game; the cell array is not cleared and simply holds, because en_o=0 and update_o=0.

Verification
REQ-040 Reset, then idle: ready_o=1 from the cycle after reset; en_o, update_o and valid_o stay 0 for 10 cycles with valid_i=0.
REQ-041 board_width_p=4, data_i=16'h0070, frames_i=1, bench cell array with dead boundary -> update_o one cycle with update_val_o=16'h0070; en_o one cycle; valid_o with data_o=16'h0222.
REQ-042 Same blinker with frames_i=2 -> data_o=16'h0070; en_o high exactly 2 cycles; valid_o first asserted 4 cycles after the handshake.
REQ-043 frames_i=0, data_i=16'hA5A5 -> en_o never asserted; valid_o asserted 2 cycles after the handshake; data_o=16'hA5A5.
REQ-044 Hold yumi_i=0 for 20 cycles in DONE -> valid_o and data_o stable throughout; valid_i pulses are ignored; yumi_i=1 -> IDLE; ready_o=1 two cycles later.
REQ-045 Assert reset_i in the 3rd RUN cycle of frames_i=5 -> en_o=0 from the reset cycle; ready_o=1 the following cycle; a new game then completes normally.
